ycbcr2rgb_pipe: RTL and testbench

- Parametrised, pipelined YCbCr-to-RGB colour converter. Next-generation replacement for the fixed 8-bit single-register converter in the JPEG decoder output path.
- Adds a valid/ready backpressure handshake, a runtime-selectable full-range (JFIF) or studio-range (BT.601) matrix, and correct clamping at both ends.
- Adds rounded fixed-point arithmetic and a sideband field carried alongside each pixel.
- Sits between the IDCT/upsampler output and the pixel writer.

---
 rtl/ycbcr2rgb_pipe.sv | 173 +++++++++++++++++
 tb/tb_ycbcr2rgb_pipe.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycbcr2rgb_pipe.sv
// Pipelined YCbCr-to-RGB converter: three register stages with valid/ready
// backpressure, per-pixel JFIF/BT.601 matrix select, rounding and clamping.
module ycbcr2rgb_pipe #(
    parameter int DW     = 8,
    parameter int FRAC   = 14,
    parameter int USER_W = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_y,
    input  logic [DW-1:0]     in_cb,
    input  logic [DW-1:0]     in_cr,
    input  logic              in_mode,
    input  logic [USER_W-1:0] in_user,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_r,
    output logic [DW-1:0]     out_g,
    output logic [DW-1:0]     out_b,
    output logic [USER_W-1:0] out_user
);

    localparam int  KW    = FRAC + 3;
    localparam int  SW    = DW + 1;
    localparam int  PW    = SW + KW;
    localparam int  ACC_W = DW + FRAC + 5;
    localparam real SCALE = real'(longint'(1) << FRAC);

    // Coefficients are round(c * 2^FRAC); the largest (2.017) needs FRAC+2 magnitude bits
    localparam logic signed [KW-1:0] KY_F   = KW'($rtoi(1.0      * SCALE + 0.5));
    localparam logic signed [KW-1:0] KRCR_F = KW'($rtoi(1.402    * SCALE + 0.5));
    localparam logic signed [KW-1:0] KGCB_F = KW'($rtoi(0.344136 * SCALE + 0.5));
    localparam logic signed [KW-1:0] KGCR_F = KW'($rtoi(0.714136 * SCALE + 0.5));
    localparam logic signed [KW-1:0] KBCB_F = KW'($rtoi(1.772    * SCALE + 0.5));
    localparam logic signed [KW-1:0] KY_S   = KW'($rtoi(1.164    * SCALE + 0.5));
    localparam logic signed [KW-1:0] KRCR_S = KW'($rtoi(1.596    * SCALE + 0.5));
    localparam logic signed [KW-1:0] KGCB_S = KW'($rtoi(0.392    * SCALE + 0.5));
    localparam logic signed [KW-1:0] KGCR_S = KW'($rtoi(0.813    * SCALE + 0.5));
    localparam logic signed [KW-1:0] KBCB_S = KW'($rtoi(2.017    * SCALE + 0.5));

    localparam logic signed [SW-1:0]    C_OFF = SW'(longint'(1) << (DW - 1));
    localparam logic signed [SW-1:0]    Y_OFF = SW'(longint'(16) << (DW - 8));
    localparam logic signed [ACC_W-1:0] RND   = ACC_W'(longint'(1) << (FRAC - 1));
    localparam logic signed [ACC_W-1:0] MAXV  = ACC_W'((longint'(1) << DW) - 1);

    // Handshake: a stage loads when empty or when its successor loads
    logic v1_q, v2_q, v3_q;
    logic load1, load2, load3;

    assign load3     = !v3_q || out_ready;
    assign load2     = !v2_q || load3;
    assign load1     = !v1_q || load2;
    assign in_ready  = load1;
    assign out_valid = v3_q;

    // S1: offset removal
    logic signed [SW-1:0] yd_d, cbd_d, crd_d;
    logic signed [SW-1:0] yd1_q, cbd1_q, crd1_q;
    logic                 m1_q;
    logic [USER_W-1:0]    u1_q;

    always_comb begin
        yd_d  = $signed({1'b0, in_y}) - (in_mode ? Y_OFF : '0);
        cbd_d = $signed({1'b0, in_cb}) - C_OFF;
        crd_d = $signed({1'b0, in_cr}) - C_OFF;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q   <= 1'b0;
            yd1_q  <= '0;
            cbd1_q <= '0;
            crd1_q <= '0;
            m1_q   <= 1'b0;
            u1_q   <= '0;
        end else if (load1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                yd1_q  <= yd_d;
                cbd1_q <= cbd_d;
                crd1_q <= crd_d;
                m1_q   <= in_mode;
                u1_q   <= in_user;
            end
        end
    end

    // S2: constant multiplies, matrix chosen by the mode captured with the pixel
    logic signed [KW-1:0] ky, krcr, kgcb, kgcr, kbcb;
    logic signed [PW-1:0] py_d, prcr_d, pgcb_d, pgcr_d, pbcb_d;
    logic signed [PW-1:0] py_q, prcr_q, pgcb_q, pgcr_q, pbcb_q;
    logic [USER_W-1:0]    u2_q;

    always_comb begin
        ky     = m1_q ? KY_S   : KY_F;
        krcr   = m1_q ? KRCR_S : KRCR_F;
        kgcb   = m1_q ? KGCB_S : KGCB_F;
        kgcr   = m1_q ? KGCR_S : KGCR_F;
        kbcb   = m1_q ? KBCB_S : KBCB_F;
        py_d   = PW'(yd1_q)  * PW'(ky);
        prcr_d = PW'(crd1_q) * PW'(krcr);
        pgcb_d = PW'(cbd1_q) * PW'(kgcb);
        pgcr_d = PW'(crd1_q) * PW'(kgcr);
        pbcb_d = PW'(cbd1_q) * PW'(kbcb);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v2_q   <= 1'b0;
            py_q   <= '0;
            prcr_q <= '0;
            pgcb_q <= '0;
            pgcr_q <= '0;
            pbcb_q <= '0;
            u2_q   <= '0;
        end else if (load2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                py_q   <= py_d;
                prcr_q <= prcr_d;
                pgcb_q <= pgcb_d;
                pgcr_q <= pgcr_d;
                pbcb_q <= pbcb_d;
                u2_q   <= u1_q;
            end
        end
    end

    // S3: sum, round half-up, clamp to [0, 2^DW-1]
    function automatic logic [DW-1:0] clamp(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] t;
        t = (acc + RND) >>> FRAC;
        if (t[ACC_W-1])    return '0;
        else if (t > MAXV) return '1;
        else               return t[DW-1:0];
    endfunction

    logic [DW-1:0]     r_d, g_d, b_d;
    logic [DW-1:0]     r_q, g_q, b_q;
    logic [USER_W-1:0] u3_q;

    always_comb begin
        r_d = clamp(ACC_W'(py_q) + ACC_W'(prcr_q));
        g_d = clamp(ACC_W'(py_q) - ACC_W'(pgcb_q) - ACC_W'(pgcr_q));
        b_d = clamp(ACC_W'(py_q) + ACC_W'(pbcb_q));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v3_q <= 1'b0;
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
            u3_q <= '0;
        end else if (load3) begin
            v3_q <= v2_q;
            if (v2_q) begin
                r_q  <= r_d;
                g_q  <= g_d;
                b_q  <= b_d;
                u3_q <= u2_q;
            end
        end
    end

    assign out_r    = r_q;
    assign out_g    = g_q;
    assign out_b    = b_q;
    assign out_user = u3_q;

endmodule

// File: tb/tb_ycbcr2rgb_pipe.sv
// Scoreboard bench for ycbcr2rgb_pipe: directed vectors, stalls, random stream
// and mid-stream reset, with a monitor comparing every output transfer.
module tb_ycbcr2rgb_pipe;

    localparam int DW     = 8;
    localparam int FRAC   = 14;
    localparam int USER_W = 2;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     in_y = '0, in_cb = '0, in_cr = '0;
    logic              in_mode = 1'b0;
    logic [USER_W-1:0] in_user = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DW-1:0]     out_r, out_g, out_b;
    logic [USER_W-1:0] out_user;

    always #5 clk = ~clk;

    ycbcr2rgb_pipe #(.DW(DW), .FRAC(FRAC), .USER_W(USER_W)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr),
        .in_mode(in_mode), .in_user(in_user),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_user(out_user)
    );

    typedef struct {
        int r; int g; int b; int user; int cyc; bit lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed directed vectors: y, cb, cr, mode -> r, g, b
    int dv_y[6]  = '{128, 255,   0,  16, 235,   0};
    int dv_cb[6] = '{128, 128, 128, 128, 128, 255};
    int dv_cr[6] = '{128, 255,   0, 128, 128, 128};
    int dv_m[6]  = '{  0,   0,   0,   1,   1,   0};
    int dv_r[6]  = '{128, 255,   0,   0, 255,   0};
    int dv_g[6]  = '{128, 164,  91,   0, 255,   0};
    int dv_b[6]  = '{128, 255,   0,   0, 255, 225};

    function automatic int clampv(input int s);
        int t;
        t = (s + 8192) >>> 14;
        if (t < 0) return 0;
        if (t > 255) return 255;
        return t;
    endfunction

    task automatic ref_px(input int y, input int cb, input int cr, input int m,
                          output int r, output int g, output int b);
        int yd, cbd, crd, ky, kr, kgb, kgr, kb;
        yd  = (m != 0) ? y - 16 : y;
        cbd = cb - 128;
        crd = cr - 128;
        if (m != 0) begin ky = 19071; kr = 26149; kgb = 6423; kgr = 13320; kb = 33047; end
        else        begin ky = 16384; kr = 22970; kgb = 5638; kgr = 11700; kb = 29032; end
        r = clampv(yd * ky + crd * kr);
        g = clampv(yd * ky - cbd * kgb - crd * kgr);
        b = clampv(yd * ky + cbd * kb);
    endtask

    // One clock of stimulus; also checks in_ready against scoreboard occupancy
    task automatic drive(input bit v, input int y, input int cb, input int cr,
                         input int m, input int u, input bit ordy,
                         input int er, input int eg, input int eb, input bit lat,
                         output bit acc);
        bit exp_rdy;
        @(negedge clk);
        in_valid  = v;
        in_y      = DW'(y);
        in_cb     = DW'(cb);
        in_cr     = DW'(cr);
        in_mode   = m[0];
        in_user   = USER_W'(u);
        out_ready = ordy;
        #1;
        exp_rdy = !(sb.size() == 3 && !ordy);
        checks++;
        if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready cyc=%0d got=%b exp=%b occ=%0d", cyc, in_ready, exp_rdy, sb.size());
        end
        acc = v && (in_ready === 1'b1);
        if (acc) sb.push_back('{er, eg, eb, u, cyc, lat});
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, ordy, 0, 0, 0, 0, acc);
    endtask

    task automatic send_dv(input int k, input int u, input bit lat);
        bit acc;
        int tries;
        acc = 0;
        tries = 0;
        while (!acc && tries < 50) begin
            drive(1, dv_y[k], dv_cb[k], dv_cr[k], dv_m[k], u, 1'b1,
                  dv_r[k], dv_g[k], dv_b[k], lat, acc);
            tries++;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout vec=%0d", k);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            idle(1, 1'b1);
            n++;
        end
        idle(1, 1'b1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: pops on each output transfer, checks holds while stalled
    initial begin : monitor
        bit                hold_prev;
        logic [DW-1:0]     pr, pg, pb;
        logic [USER_W-1:0] pu;
        exp_t              e;
        hold_prev = 0;
        pr = '0; pg = '0; pb = '0; pu = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rstn) begin
                hold_prev = 0;
                continue;
            end
            if (hold_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_r !== pr || out_g !== pg || out_b !== pb || out_user !== pu) begin
                    errors++;
                    $display("FAIL hold cyc=%0d got v=%b %0d,%0d,%0d u=%0d exp v=1 %0d,%0d,%0d u=%0d",
                             cyc, out_valid, out_r, out_g, out_b, out_user, pr, pg, pb, pu);
                end
            end
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_out cyc=%0d got %0d,%0d,%0d exp no pixel", cyc, out_r, out_g, out_b);
                end else if (out_ready) begin
                    e = sb.pop_front();
                    checks++;
                    if (out_r !== DW'(e.r) || out_g !== DW'(e.g) || out_b !== DW'(e.b) || out_user !== USER_W'(e.user)) begin
                        errors++;
                        $display("FAIL pixel cyc=%0d got %0d,%0d,%0d u=%0d exp %0d,%0d,%0d u=%0d",
                                 cyc, out_r, out_g, out_b, out_user, e.r, e.g, e.b, e.user);
                    end
                    if (e.lat) begin
                        checks++;
                        if (cyc - e.cyc != 3) begin
                            errors++;
                            $display("FAIL latency got=%0d exp=3", cyc - e.cyc);
                        end
                    end
                end
                hold_prev = !out_ready;
                pr = out_r; pg = out_g; pb = out_b; pu = out_user;
            end else begin
                hold_prev = 0;
            end
        end
    end

    initial begin : stim
        bit acc;
        int nacc, k, r, g, b, y, cb, cr, m, u, tries;

        // Reset state
        repeat (3) @(negedge clk);
        #3 rstn = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end

        // Isolated directed vectors, latency checked
        for (int i = 0; i < 6; i++) begin
            send_dv(i, i % 4, 1'b1);
            drain();
        end

        // Back-to-back alternating modes
        send_dv(3, 1, 1'b1);
        send_dv(0, 2, 1'b1);
        send_dv(4, 3, 1'b1);
        send_dv(1, 0, 1'b1);
        send_dv(3, 2, 1'b1);
        send_dv(2, 1, 1'b1);
        drain();

        // Stall: out_ready low for 10 cycles with in_valid held high
        k = 0;
        nacc = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, dv_y[k % 6], dv_cb[k % 6], dv_cr[k % 6], dv_m[k % 6], k % 4, 1'b0,
                  dv_r[k % 6], dv_g[k % 6], dv_b[k % 6], 1'b0, acc);
            if (acc) begin nacc++; k++; end
        end
        checks++;
        if (nacc != 3) begin errors++; $display("FAIL stall_accepts got=%0d exp=3", nacc); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
        // Release: drain in order while new pixels enter at 1/cycle
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, dv_y[k % 6], dv_cb[k % 6], dv_cr[k % 6], dv_m[k % 6], k % 4, 1'b1,
                  dv_r[k % 6], dv_g[k % 6], dv_b[k % 6], 1'b0, acc);
            if (acc) begin nacc++; k++; end
        end
        checks++;
        if (nacc != 6) begin errors++; $display("FAIL release_rate got=%0d exp=6", nacc); end
        drain();

        // Random stream with random backpressure
        for (int i = 0; i < 64; i++) begin
            y  = $urandom_range(0, 255);
            cb = $urandom_range(0, 255);
            cr = $urandom_range(0, 255);
            m  = $urandom_range(0, 1);
            u  = $urandom_range(0, 3);
            ref_px(y, cb, cr, m, r, g, b);
            if ($urandom_range(0, 9) == 0) idle(1, ($urandom_range(0, 99) >= 40));
            acc = 0;
            tries = 0;
            while (!acc && tries < 200) begin
                drive(1, y, cb, cr, m, u, ($urandom_range(0, 99) >= 40), r, g, b, 1'b0, acc);
                tries++;
            end
            if (!acc) begin
                checks++; errors++;
                $display("FAIL random_send_timeout idx=%0d", i);
            end
        end
        drain();

        // Reset with two pixels in flight
        send_dv(0, 1, 1'b0);
        send_dv(1, 2, 1'b0);
        idle(2, 1'b0);
        #2;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got=%b exp=1", out_valid); end
        rstn = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset got=%b exp=0", out_valid); end
        @(negedge clk);
        #3 rstn = 1'b1;
        idle(8, 1'b1);
        send_dv(5, 3, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
